// File: rtl/hour_unit_digit.sv
// Hours-units digit stage of the 24-hour clock.
// It counts hour increments from the minutes carry and from a synchronised,
// edge-detected adjust button. The digit wraps at 9, or at 3 when the tens
// digit reads 2. A one-cycle carry pulse advances the downstream tens stage.
// The stage also drives a registered 7-segment pattern of its own digit.
module hour_unit_digit #(
  parameter bit ADJ_CARRY   = 1'b0,  // 1: an adjust-driven wrap also pulses carry_out
  parameter int SYNC_STAGES = 2      // adj_btn synchronizer depth, must be >= 2
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       adj_btn,
  input  logic [1:0] tens_in,
  output logic [3:0] bcd_out,
  output logic       carry_out,
  output logic [7:0] seg_data
);

  // Segment pattern {a,b,c,d,e,f,g,dp}. The decimal point is never lit.
  function automatic logic [7:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_decode = 8'hFC;
      4'd1:    seg_decode = 8'h60;
      4'd2:    seg_decode = 8'hDA;
      4'd3:    seg_decode = 8'hF2;
      4'd4:    seg_decode = 8'h66;
      4'd5:    seg_decode = 8'hB6;
      4'd6:    seg_decode = 8'hBE;
      4'd7:    seg_decode = 8'hE0;
      4'd8:    seg_decode = 8'hFE;
      4'd9:    seg_decode = 8'hF6;
      default: seg_decode = 8'h00;
    endcase
  endfunction

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;
  logic [3:0]             bcd_q, bcd_d;
  logic                   carry_q, carry_d;
  logic [7:0]             seg_q, seg_d;

  logic       sync_out;
  logic       adj_pulse;
  logic       inc;
  logic [3:0] limit;

  assign sync_out  = sync_q[SYNC_STAGES-1];
  assign adj_pulse = sync_out & ~edge_q;
  assign inc       = tick_in | adj_pulse;
  // tens_in == 3 is illegal and is treated like 2, so tens_in[1] alone selects the 24h limit.
  assign limit     = tens_in[1] ? 4'd3 : 4'd9;

  // Next-state logic: synchronizer shift, edge history, digit count, carry and segment decode.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
    sync_d  = {sync_q[SYNC_STAGES-2:0], adj_btn};
    edge_d  = sync_out;
    bcd_d   = bcd_q;
    carry_d = 1'b0;
    seg_d   = seg_decode(bcd_q);

    if (inc) begin
      if (bcd_q >= limit) begin
        // >= also catches a digit left out of range after tens was adjusted to 2.
        bcd_d   = 4'd0;
        carry_d = tick_in | ADJ_CARRY;
      end else begin
        bcd_d   = bcd_q + 4'd1;
      end
    end
  end

  // State registers with synchronous reset. Reset overrides every other event.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      sync_q  <= '0;
      edge_q  <= 1'b0;
      bcd_q   <= 4'd0;
      carry_q <= 1'b0;
      seg_q   <= 8'hFC;
    end else begin
      sync_q  <= sync_d;
      edge_q  <= edge_d;
      bcd_q   <= bcd_d;
      carry_q <= carry_d;
      seg_q   <= seg_d;
    end
  end

  assign bcd_out   = bcd_q;
  assign carry_out = carry_q;
  assign seg_data  = seg_q;

endmodule

// File: tb/tb_hour_unit_digit.sv
// Scoreboard bench for hour_unit_digit.
// The stimulus process drives one cycle at a time. At each rising edge it
// advances a behavioural clock-digit model and queues the expected outputs.
// A monitor process pops one entry per cycle on the falling edge and compares.
module tb_hour_unit_digit;

  localparam int SYNC = 2;

  typedef struct {
    int         digit;
    logic       carry;
    logic [7:0] seg;
  } exp_t;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       tick_in = 1'b0;
  logic       adj_btn = 1'b0;
  logic [1:0] tens_in = 2'd0;
  logic [3:0] bcd_out;
  logic       carry_out;
  logic [7:0] seg_data;

  hour_unit_digit #(.ADJ_CARRY(1'b0), .SYNC_STAGES(SYNC)) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .tick_in  (tick_in),
    .adj_btn  (adj_btn),
    .tens_in  (tens_in),
    .bcd_out  (bcd_out),
    .carry_out(carry_out),
    .seg_data (seg_data)
  );

  always #5 clk_in = ~clk_in;

  exp_t exp_q[$];
  int   n_compared = 0;
  int   n_failed   = 0;

  // Reference model state: the displayed hour-units value, plus the adj_btn
  // level seen at every edge. A press is a rise in that level, and it takes
  // effect SYNC edges after the rise. Any reset wipes out earlier history.
  int   m_digit   = 0;
  logic btn_log[$];
  int   edge_n    = -1;
  int   last_rst  = -1;

  function automatic logic btn_at(int e);
    if (e < 0 || e <= last_rst) return 1'b0;
    return btn_log[e];
  endfunction

  function automatic logic [7:0] seg_of(int d);
    logic [7:0] tab [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                             8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};
    if (d < 0 || d > 9) return 8'h00;
    return tab[d];
  endfunction

  // Called right after a rising edge. The inputs still hold the values that edge sampled.
  task automatic model_edge();
    exp_t e;
    logic press;
    int   lim;
    edge_n++;
    btn_log.push_back(adj_btn);
    if (rst) begin
      last_rst = edge_n;
      m_digit  = 0;
      e.carry  = 1'b0;
      e.seg    = 8'hFC;
    end else begin
      press  = btn_at(edge_n - SYNC) && !btn_at(edge_n - SYNC - 1);
      lim    = (tens_in >= 2) ? 3 : 9;
      e.seg  = seg_of(m_digit);
      e.carry = 1'b0;
      if (tick_in || press) begin
        if (m_digit >= lim) begin
          m_digit = 0;
          e.carry = tick_in;  // adjust-only wraps are silent in this configuration
        end else begin
          m_digit = m_digit + 1;
        end
      end
    end
    e.digit = m_digit;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic r, input logic t, input logic b, input logic [1:0] tn);
    rst     = r;
    tick_in = t;
    adj_btn = b;
    tens_in = tn;
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
  endtask

  // Tick with tens = 0 until the model digit reaches the target.
  task automatic tick_to(input int target);
    for (int k = 0; k < 12 && m_digit != target; k++) step(1'b0, 1'b1, 1'b0, 2'd0);
  endtask

  // Monitor: one expected entry per clock cycle, compared away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_compared++;
        if (bcd_out !== 4'(e.digit) || carry_out !== e.carry || seg_data !== e.seg) begin
          n_failed++;
          $display("FAIL out@edge: got bcd=%0d carry=%b seg=%h, expected bcd=%0d carry=%b seg=%h (t=%0t)",
                   bcd_out, carry_out, seg_data, e.digit, e.carry, e.seg, $time);
        end
      end
    end
  end

  initial begin
    int drain;
    @(negedge clk_in);

    // Reset held two cycles with tick_in high: ticks are ignored.
    step(1'b1, 1'b1, 1'b0, 2'd0);
    step(1'b1, 1'b1, 1'b0, 2'd0);

    // Ten ticks spaced three cycles apart: 1..9 then a wrap to 0 with carry.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0, 2'd0);
      step(1'b0, 1'b0, 1'b0, 2'd0);
      step(1'b0, 1'b0, 1'b0, 2'd0);
    end

    // 24h limit: with tens=2, digit 3 wraps with carry. With tens=1, digit 3 goes to 4.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 2'd2);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 2'd1);
    step(1'b0, 1'b0, 1'b0, 2'd1);

    // Adjust at digit 9 with the button held 20 cycles: one silent wrap.
    tick_to(9);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 2'd0);
    for (int i = 0; i < 4; i++)  step(1'b0, 1'b0, 1'b0, 2'd0);

    // Tick coinciding with an adjust pulse at digit 4 gives one increment.
    tick_to(4);
    step(1'b0, 1'b0, 1'b1, 2'd0);
    step(1'b0, 1'b0, 1'b1, 2'd0);
    step(1'b0, 1'b1, 1'b1, 2'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 2'd0);

    // Reset in the same cycle that would have produced a carry.
    tick_to(9);
    step(1'b1, 1'b1, 1'b0, 2'd0);
    step(1'b0, 1'b0, 1'b0, 2'd0);

    // Out-of-range digit 7 with tens=2 wraps to 0 on the next tick.
    tick_to(7);
    step(1'b0, 1'b0, 1'b0, 2'd2);
    step(1'b0, 1'b1, 1'b0, 2'd2);
    step(1'b0, 1'b0, 1'b0, 2'd2);

    // Random traffic: sparse resets, frequent ticks, slow button and tens changes.
    begin
      logic       b  = 1'b0;
      logic [1:0] tn = 2'd0;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(19, 0) == 0) b = ~b;
        if ($urandom_range(29, 0) == 0) tn = 2'($urandom_range(3, 0));
        step(1'($urandom_range(99, 0) == 0), 1'($urandom_range(3, 0) == 0), b, tn);
      end
    end
    step(1'b0, 1'b0, 1'b0, 2'd0);

    // Wait for the monitor to drain the scoreboard. A bounded wait counts a stall as a failure.
    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(negedge clk_in);
      drain++;
    end
    #1;
    if (exp_q.size() > 0) begin
      n_failed++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
